// File: rtl/edabk_uart_pkg.sv
// Shared UART receive definitions: FSM states, baud-code rate table and the
// oversample divisor helper.
package edabk_uart_pkg;

  localparam int unsigned CFG_DATA_WIDTH = 8;
  localparam int          DIV_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int unsigned BAUD_RATE [8] = '{
    32'd1200, 32'd2400, 32'd4800, 32'd9600,
    32'd19200, 32'd38400, 32'd57600, 32'd115200
  };

  // Rounded clk/(16*baud), never below 1 so the tick generator always advances.
  function automatic int unsigned div_for(input int unsigned clk_freq, input logic [2:0] code);
    int unsigned baud;
    int unsigned d;
    baud = BAUD_RATE[code];
    d    = (clk_freq + 32'd8 * baud) / (32'd16 * baud);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/edabk_rx_tick_gen.sv
// 16x oversample tick generator: one-clock tick every div clocks, realigned by
// restart so the first tick lands on the clock right after it.
module edabk_rx_tick_gen
  import edabk_uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = cnt_q - DIV_W'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = div - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/edabk_receiver.sv
// UART receive engine: 2-flop line synchronizer, 16x oversampled mid-bit FSM and
// a one-deep output register with valid/read handshake.
module edabk_receiver
  import edabk_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int unsigned CLK_FREQ   = 1_843_200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            baudrate,
  input  logic                  rx_in,
  input  logic                  rx_read,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int                BCNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_WIDTH - 1);

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [DIV_W-1:0]      div_tab [8];
  logic [DIV_W-1:0]      div_q;
  logic                  tick;

  rx_state_e             state_q, state_d;
  logic [3:0]            scnt_q, scnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic                  restart;
  logic                  sample_pt;
  logic                  good_frame;
  logic                  bad_frame;

  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end
  assign rx_s = sync_q[1];

  // Divisors are elaboration-time constants; only a mux is left in hardware.
  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    assign div_tab[gi] = DIV_W'(div_for(CLK_FREQ, 3'(gi)));
  end

  edabk_rx_tick_gen u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      div_q   <= DIV_W'(1);
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      if (state_q == ST_IDLE) begin
        div_q <= div_tab[baudrate];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          scnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (scnt_q == 4'd7) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shift_d[bcnt_q] = rx_s;
            if (bcnt_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            state_d = rx_s ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    restart    = (state_q == ST_IDLE) && !rx_s;
    sample_pt  = tick && (scnt_q == 4'd15);
    good_frame = (state_q == ST_STOP) && sample_pt && rx_s;
    bad_frame  = (state_q == ST_STOP) && sample_pt && !rx_s;
  end

  // A pop on the completion edge frees the register for the new word.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (good_frame && (!rx_valid_q || rx_read)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_read) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= bad_frame;
      overrun_q   <= good_frame && rx_valid_q && !rx_read;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_edabk_receiver.sv
// Scoreboard bench for edabk_receiver: expected words are queued when a frame is
// driven and compared by a monitor whenever the DUT loads its output register.
module tb_edabk_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baudrate;
  logic       rx_in;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int load_cnt     = 0;
  int load_cyc     = 0;
  int fe_rises     = 0;
  int fe_cycles    = 0;
  int ov_rises     = 0;
  int ov_cycles    = 0;
  int frame_start  = 0;
  int lat1         = 154;

  logic valid_prev = 1'b0;
  logic read_prev  = 1'b0;
  logic fe_prev    = 1'b0;
  logic ov_prev    = 1'b0;

  logic [31:0] sb [$];

  edabk_receiver #(
    .DATA_WIDTH (8),
    .CLK_FREQ   (1_843_200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baudrate  (baudrate),
    .rx_in     (rx_in),
    .rx_read   (rx_read),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A load is a rising rx_valid, or rx_valid still high after a pop edge.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rx_valid && (!valid_prev || read_prev)) begin
      exp_w    = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
      load_cnt = load_cnt + 1;
      load_cyc = cyc;
      $display("word %0d: rx_data=0x%02h at cycle %0d", load_cnt, rx_data, cyc);
      check_val("rx_data", 32'(rx_data), exp_w);
    end
    if (frame_err) fe_cycles = fe_cycles + 1;
    if (frame_err && !fe_prev) fe_rises = fe_rises + 1;
    if (overrun) ov_cycles = ov_cycles + 1;
    if (overrun && !ov_prev) ov_rises = ov_rises + 1;
    valid_prev = rx_valid;
    read_prev  = rx_read;
    fe_prev    = frame_err;
    ov_prev    = overrun;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit edges at round-down multiples of per_x100/100 clocks; caller is aligned
  // just after a posedge. rst_bit >= 0 pulses reset inside that data bit.
  task automatic send_frame(input logic [7:0] data, input int per_x100, input int stop_bits,
                            input logic stop_val, input int rst_bit);
    int   start;
    int   nbits;
    logic lvl;
    start       = cyc;
    frame_start = start;
    nbits       = 9 + stop_bits;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k <= 8) lvl = data[k-1];
      else lvl = stop_val;
      rx_in = lvl;
      if (k >= 1 && (k - 1) == rst_bit) begin
        idle(4);
        reset = 1'b1;
        idle(1);
        @(negedge clk);
        check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_val("rst_rx_data", 32'(rx_data), 32'd0);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      while (cyc < start + ((k + 1) * per_x100) / 100) idle(1);
    end
    rx_in = 1'b1;
  endtask

  task automatic wait_load(input string tag, input int base, input int budget);
    int n;
    n = 0;
    while (load_cnt <= base && n < budget) begin
      idle(1);
      n++;
    end
    check_val({"load_seen_", tag}, 32'(load_cnt > base), 32'd1);
  endtask

  task automatic pop_word();
    rx_read = 1'b1;
    idle(1);
    rx_read = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ov0;
    int ovc0;
    int fe0;
    int fec0;
    int t_first;
    int lat;

    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_read  = 1'b0;
    baudrate = 3'b111;
    idle(4);
    @(negedge clk);
    check_val("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_val("reset_rx_data", 32'(rx_data), 32'd0);
    check_val("reset_frame_err", 32'(frame_err), 32'd0);
    check_val("reset_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);

    // Basic frame with latency window and pop
    base = load_cnt;
    sb.push_back(32'h55);
    send_frame(8'h55, 1600, 1, 1'b1, -99);
    wait_load("basic", base, 400);
    lat = load_cyc - (frame_start + 1);
    check_val($sformatf("latency_%0d_in_150_156", lat), 32'(lat >= 150 && lat <= 156), 32'd1);
    if (lat >= 150 && lat <= 156) lat1 = lat;
    pop_word();
    @(negedge clk);
    check_val("valid_after_read", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back into a full register: second word dropped
    base = load_cnt;
    ov0  = ov_rises;
    ovc0 = ov_cycles;
    sb.push_back(32'hAA);
    send_frame(8'hAA, 1600, 1, 1'b1, -99);
    send_frame(8'hAB, 1600, 1, 1'b1, -99);
    idle(8);
    check_val("b2b_loads", 32'(load_cnt - base), 32'd1);
    check_val("b2b_overrun_pulses", 32'(ov_rises - ov0), 32'd1);
    check_val("b2b_overrun_cycles", 32'(ov_cycles - ovc0), 32'd1);
    @(negedge clk);
    check_val("b2b_rx_data_kept", 32'(rx_data), 32'hAA);
    check_val("b2b_rx_valid", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1;
    pop_word();
    idle(4);

    // Back-to-back with a pop on the second completion edge
    base    = load_cnt;
    ov0     = ov_rises;
    sb.push_back(32'hAA);
    sb.push_back(32'hAB);
    t_first = cyc;
    fork
      begin
        send_frame(8'hAA, 1600, 1, 1'b1, -99);
        send_frame(8'hAB, 1600, 1, 1'b1, -99);
      end
      begin
        while (cyc < t_first + 160 + lat1) idle(1);
        rx_read = 1'b1;
        idle(1);
        rx_read = 1'b0;
      end
    join
    idle(8);
    check_val("b2b_pop_loads", 32'(load_cnt - base), 32'd2);
    check_val("b2b_pop_overrun", 32'(ov_rises - ov0), 32'd0);
    @(negedge clk);
    check_val("b2b_pop_rx_data", 32'(rx_data), 32'hAB);
    check_val("b2b_pop_rx_valid", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1;
    pop_word();
    idle(4);

    // Framing error: stop bit held low for 40 bit-times
    base = load_cnt;
    fe0  = fe_rises;
    fec0 = fe_cycles;
    send_frame(8'h3C, 1600, 40, 1'b0, -99);
    idle(40);
    check_val("ferr_pulses", 32'(fe_rises - fe0), 32'd1);
    check_val("ferr_cycles", 32'(fe_cycles - fec0), 32'd1);
    check_val("ferr_no_load", 32'(load_cnt - base), 32'd0);
    @(negedge clk);
    check_val("ferr_rx_valid", 32'(rx_valid), 32'd0);
    @(posedge clk);
    #1;
    base = load_cnt;
    sb.push_back(32'hC3);
    send_frame(8'hC3, 1600, 1, 1'b1, -99);
    wait_load("after_ferr", base, 400);
    pop_word();
    idle(4);

    // False start: 4-clock glitch
    base  = load_cnt;
    fe0   = fe_rises;
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(300);
    check_val("glitch_no_load", 32'(load_cnt - base), 32'd0);
    check_val("glitch_no_ferr", 32'(fe_rises - fe0), 32'd0);
    base = load_cnt;
    sb.push_back(32'h5A);
    send_frame(8'h5A, 1600, 1, 1'b1, -99);
    wait_load("after_glitch", base, 400);
    check_val("after_glitch_latency", 32'(load_cyc - (frame_start + 1)), 32'(lat1));
    pop_word();
    idle(4);

    // 9600 baud (DIV 12), line 2 % fast: 192 -> 188.16 clk per bit
    baudrate = 3'b011;
    idle(4);
    base = load_cnt;
    sb.push_back(32'hA5);
    send_frame(8'hA5, 18816, 1, 1'b1, -99);
    wait_load("rate_9600", base, 2500);
    pop_word();
    baudrate = 3'b111;
    idle(30);

    // Reset during data bit 4 of 0xF0 (line stays high afterwards)
    base = load_cnt;
    send_frame(8'hF0, 1600, 1, 1'b1, 4);
    idle(20);
    check_val("rst_abort_no_load", 32'(load_cnt - base), 32'd0);
    base = load_cnt;
    sb.push_back(32'h0F);
    send_frame(8'h0F, 1600, 1, 1'b1, -99);
    wait_load("after_reset", base, 400);
    pop_word();
    idle(4);

    check_val("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/edabk_receiver.md
# edabk_receiver

UART receive engine, the counterpart of `edabk_transmitter`. It recovers `CFG_DATA_WIDTH`-bit frames from the serial line `rx_in` using 16x oversampling with mid-bit sampling. Each received word is presented on a one-deep output register with a valid/read handshake, so `edabk_io_fifo` or a host can drain it. Baud rate is chosen with the same 3-bit `baudrate` code as `baud_generator`. The block runs on the system clock, not on `bclk`.

## Interface
- `DATA_WIDTH`, default `CFG_DATA_WIDTH` (8): payload bits per frame, sent LSB first.
- `CLK_FREQ`, default 1_843_200: `clk` frequency in Hz. It sets the oversample divisors.
- `clk`: in, 1 bit. Single clock for all logic.
- `reset`: in, 1 bit. Synchronous, active-high. One clock and one reset only.
- `baudrate`: in, 3 bits. Rate code: 000=1200, 001=2400, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- `rx_in`: in, 1 bit. Asynchronous serial line; idles high.
- `rx_data`: out, `DATA_WIDTH` bits. Last accepted word.
- `rx_valid`: out, 1 bit. `rx_data` holds an unread word.
- `rx_read`: in, 1 bit. Consumer pop; honoured only while `rx_valid` = 1.
- `frame_err`: out, 1 bit. One-cycle pulse when a stop bit is sampled low.
- `overrun`: out, 1 bit. One-cycle pulse when a good frame is dropped because the output register is full.

## Operation
- Line synchronizer:
  - `rx_in` passes through 2 flops; both reset to 1.
  - The FSM uses only the second flop, `rx_s`.
- Tick generator:
  - Divisor `DIV = (CLK_FREQ + 8*baud) / (16*baud)`, integer division, minimum 1.
  - Emits a one-`clk` `tick` every `DIV` clocks.
  - `baudrate` is latched only in IDLE; a change mid-frame has no effect until the next frame.
  - The divider restarts, with a tick on the first clock, on the IDLE→START transition.
- FSM states IDLE, START, DATA, STOP, BREAK; 4-bit tick counter `scnt`; bit index `bcnt`.
  - IDLE: `rx_s` = 0 → START, `scnt` = 0.
  - START: counts ticks. At `scnt` = 7 (mid-bit): if `rx_s` = 0 → DATA with `scnt`, `bcnt` = 0; else false start → IDLE, no output.
  - DATA: samples `rx_s` each time `scnt` wraps 15→0 (16 ticks after the previous sample) and shifts it into bit `bcnt` (LSB first). After sample `DATA_WIDTH`-1 → STOP.
  - STOP: samples 16 ticks after the last data bit.
    - `rx_s` = 1: frame good → IDLE. The next start bit can be detected immediately (back-to-back frames).
    - `rx_s` = 0: pulse `frame_err`, discard the word → BREAK.
  - BREAK: waits for `rx_s` = 1 → IDLE.
- Output register, on a good frame:
  - `rx_valid` = 0, or `rx_read` = 1 this cycle: load `rx_data`, `rx_valid` = 1.
  - `rx_valid` = 1 and `rx_read` = 0: keep the old word, pulse `overrun`.
  - `rx_read` with no new frame: `rx_valid` → 0; `rx_data` holds its value.
  - `rx_read` while `rx_valid` = 0 is ignored.
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, FSM = IDLE, synchronizer = 1.
  - Reset mid-frame aborts the frame; nothing is delivered.
  - If `rx_in` is held low through reset release, the first frame starts after the low level is seen (start detect is level-based in IDLE).

## Timing
- Synchronizer latency: 2 `clk`.
- Sample point: mid-bit, ±1 `DIV` of the ideal 8/16 position.
- `rx_valid` rises on the `clk` after the stop-bit sample. `frame_err` and `overrun` pulse on that same `clk`.
- With `DIV` = 1, `rx_valid` rises 150–156 `clk` after the first `clk` edge that sees `rx_in` = 0. The bench checks this window.
- `rx_read` → `rx_valid` falls on the next edge. A pop and a new load can occur on the same edge.
- Tolerated baud mismatch: ±3 % total.

## Structure
- Package `edabk_uart_pkg` holds:
  - the FSM state enum;
  - the baud code→rate constant table;
  - a function `div_for(clk_freq, code)` returning the oversample divisor.
- Sub-module `edabk_rx_tick_gen`: ports `clk`, `reset`, `restart`, `div` → `tick`. The FSM, shift register and output register live in `edabk_receiver`.

## Test plan
- **Basic frame:** `CLK_FREQ` = 1_843_200, `baudrate` = 3'b111, line driven with 0x55, one stop bit. Required: `rx_valid` within 150–156 clk, `rx_data` = 0x55; `rx_read` clears `rx_valid` next clk.
- **Back-to-back, full register:** frames 0xAA then 0xAB with no idle gap and no reads. Required: first word = 0xAA, `overrun` pulses once, `rx_data` stays 0xAA. Repeat with `rx_read` asserted on the second completion cycle: `rx_data` = 0xAB, `rx_valid` stays 1.
- **Framing error:** frame 0x3C with the stop bit driven 0 for 40 bit-times, then released high. Required: `frame_err` one-cycle pulse, `rx_valid` stays 0; the next frame 0xC3 is received correctly.
- **False start:** glitch `rx_in` low for 4 clk at `DIV` = 1. Required: no `rx_valid`, no `frame_err`, FSM back in IDLE.
- **Rate coverage:** `baudrate` = 3'b011 (`DIV` = 12), frame 0xA5, with the bit period of the line driver set 2 % fast. Required: `rx_data` = 0xA5.
- **Reset mid-frame:** `reset` pulse at data bit 4, then frame 0x0F. Required: all outputs 0 during reset, only 0x0F delivered.
